jtag_tunnel_host: RTL
=====================

// Module: jtag_tunnel_host
// PURPOSE
// Host-side initiator for the BSCANE2 USER-chain JTAG tunnel. Takes a scan request (IR/DR select,
// length, payload), drives an outer TAP that already holds the USER instruction through one DR
// scan carrying a tunnel frame, and returns the bits the inner TAP shifted out. Used as the
// on-board or sim master feeding the tunnel decoder; one request in flight at a time.
// PARAMETERS
// DATA_W   64  max payload bits per scan; legal req_len is 1..min(DATA_W,127)
// CLK_DIV  4   clk cycles per tck half-period (>=1); tck freq = f_clk/(2*CLK_DIV)
// PORTS
// clk        in   1       system clock
// rst_n      in   1       async active-low reset
// req_valid  in   1       scan request valid
// req_ready  out  1       high only in IDLE; transfer when valid&&ready
// req_is_dr  in   1       1 = inner DR scan, 0 = inner IR scan
// req_len    in   7       payload length in bits
// req_data   in   DATA_W  payload, bit0 shifted first
// rsp_valid  out  1       1-cycle pulse: scan complete
// rsp_err    out  1       qualified by rsp_valid: request rejected, no tck activity
// rsp_data   out  DATA_W  captured inner-TAP TDO, bit0 first; bits >= len are 0
// tck        out  1       outer TAP clock
// tms        out  1       outer TAP mode select
// tdi        out  1       outer TAP data in
// tdo        in   1       outer TAP data out (sampled on tck rise)
// BEHAVIOUR
// - Reset (async assert, sync release): tck=0, tms=0, tdi=0, req_ready=1, rsp_valid=0,
//   rsp_err=0, rsp_data=0, FSM=IDLE, divider=0. Reset mid-scan aborts immediately; no recovery seq.
// - tck: free counter of CLK_DIV clk cycles per phase, runs only outside IDLE/DONE; tck idles low.
//   tms/tdi update only on tck falling edges (and on entry); tdo sampled on tck rising edges.
// - Accept: req_len==0 or req_len>DATA_W -> next cycle rsp_valid=1, rsp_err=1, back to IDLE.
// - Frame (F = 10+len bits, index k=0..F-1, driven on tdi during outer Shift-DR):
//   k=0 type bit = req_is_dr; k=1..7 req_len LSB first; k=8..7+len payload bit k-8;
//   k=8+len, 9+len pad bits = 0.
// - FSM, one state step per tck rising edge unless noted:
//   IDLE : req_ready=1; on accept latch req, go PRE.
//   PRE  : 3 tck cycles, tms=1,0,0 (Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR), tdi=0.
//   SHIFT: F tck cycles, tdi=frame[k], tms=0 except tms=1 on k=F-1 (-> Exit1-DR).
//          On rising edge of k=8..7+len capture tdo into rsp_data[k-8].
//   POST : 2 tck cycles, tms=1 then 0 (Update-DR -> Run-Test/Idle), tdi=0.
//   DONE : after final falling edge, one clk cycle with rsp_valid=1, rsp_err=0; go IDLE.
// - Total scan = 3+F+2 = 15+len tck cycles; req_valid ignored while busy; rsp_data held until next
//   accept (cleared at accept).
// - Bit counter 8 bits wide (F max 137), no wrap. tdo while inner tdo_en low reads 1; passed as-is.
// TESTING
// - DR scan, len=32, data=0xDEADBEEF, tdo loopback model of tunnel+32-bit inner DR preloaded
//   0x12345678 -> 47 tck, tms pattern 1,0,0,0x41(0),1,1,0; rsp_data=0x12345678, inner DR=0xDEADBEEF.
// - IR scan, len=5, data=0x11 -> frame bit0=0, bits1..7=0000101b LSB-first; inner IR=0x11,
//   rsp_data=capture value 0x01; rsp_err=0.
// - req_len=0 and req_len=DATA_W+1 -> rsp_err=1 pulse one cycle after accept, tck never toggles.
// - len=1 and len=DATA_W boundaries -> tms=1 exactly at k=F-1; rsp_data[DATA_W-1] correct; 16/79 tck.
// - CLK_DIV=1 and CLK_DIV=7 -> tck period 2/14 clk, tms/tdi stable across every tck rise.
// - Assert rst_n low at k=20 of a len=64 scan -> all outputs reset values same cycle; next request
//   after release completes normally.

Source files
------------

// File: rtl/jtag_tunnel_host.sv
// JTAG tunnel host: one request becomes one outer DR scan of 15+len tck cycles; rsp pulses one clk after the final tck fall.
// Single request in flight; req_ready is high only in IDLE, and req_valid is ignored while a scan runs.
module jtag_tunnel_host #(
  parameter int DATA_W  = 64,
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_is_dr,
  input  logic [6:0]        i_req_len,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_tck,
  output logic              o_tms,
  output logic              o_tdi,
  input  logic              i_tdo
);

  localparam int              FW      = DATA_W + 10;
  localparam int              LMAX_I  = (DATA_W > 127) ? 127 : DATA_W;
  localparam logic [7:0]      LMAX    = 8'(LMAX_I);
  localparam int              DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_END = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REJ,
    S_PRE,
    S_SHIFT,
    S_POST,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic [DW-1:0]     r_div;
  logic              r_tck;
  logic              r_tms;
  logic              r_tdi;
  logic [6:0]        r_len;
  logic [FW-1:0]     r_frame;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_active;
  logic              w_div_end;
  logic              w_rise;
  logic              w_fall;
  logic              w_accept;
  logic              w_bad;
  logic              w_last;
  logic              w_cap;
  logic              w_tms_nxt;
  logic              w_tdi_nxt;
  logic [7:0]        w_flast;
  logic [7:0]        w_bidx;
  logic [DATA_W-1:0] w_mask;
  logic [FW-1:0]     w_bitsel;

  assign w_active  = (r_state == S_PRE) || (r_state == S_SHIFT) || (r_state == S_POST);
  assign w_div_end = (r_div == DIV_END);
  assign w_rise    = w_active && w_div_end && !r_tck;
  assign w_fall    = w_active && w_div_end && r_tck;
  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  assign w_bad     = (i_req_len == 7'd0) || ({1'b0, i_req_len} > LMAX);
  assign w_flast   = {1'b0, r_len} + 8'd9;
  assign w_bidx    = r_cnt - 8'd8;
  // Payload bits above len are zeroed so the two pad bits fall out of the frame vector for free.
  assign w_mask    = ~({DATA_W{1'b1}} << i_req_len);
  assign w_last    = ((r_state == S_PRE)   && (r_cnt == 8'd2))    ||
                     ((r_state == S_SHIFT) && (r_cnt == w_flast)) ||
                     ((r_state == S_POST)  && (r_cnt == 8'd1));
  assign w_cap     = w_rise && (r_state == S_SHIFT) && (r_cnt >= 8'd8) &&
                     (r_cnt < (8'd8 + {1'b0, r_len}));
  assign w_bitsel  = {{(FW-1){1'b0}}, 1'b1} << w_cnt_nxt;

  // State and in-state tck count advance on tck falls, so rising edges see a stable step.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = w_bad ? S_REJ : S_PRE;
        end
      end
      S_REJ, S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_PRE, S_SHIFT, S_POST: begin
        if (w_fall) begin
          if (w_last) begin
            w_cnt_nxt = 8'd0;
            case (r_state)
              S_PRE:   w_state_nxt = S_SHIFT;
              S_SHIFT: w_state_nxt = S_POST;
              default: w_state_nxt = S_DONE;
            endcase
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_tms_nxt = 1'b0;
    w_tdi_nxt = 1'b0;
    case (w_state_nxt)
      S_PRE:   w_tms_nxt = (w_cnt_nxt == 8'd0);
      S_SHIFT: begin
        w_tms_nxt = (w_cnt_nxt == w_flast);
        w_tdi_nxt = |(r_frame & w_bitsel);
      end
      S_POST:  w_tms_nxt = (w_cnt_nxt == 8'd0);
      default: begin
        w_tms_nxt = 1'b0;
        w_tdi_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div      <= '0;
      r_tck      <= 1'b0;
      r_tms      <= 1'b0;
      r_tdi      <= 1'b0;
      r_len      <= 7'd0;
      r_frame    <= '0;
      r_rsp_data <= '0;
    end else begin
      r_tms <= w_tms_nxt;
      r_tdi <= w_tdi_nxt;
      if (w_active) begin
        if (w_div_end) begin
          r_div <= '0;
          r_tck <= !r_tck;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end else begin
        r_div <= '0;
        r_tck <= 1'b0;
      end
      if (w_accept) begin
        r_len      <= i_req_len;
        r_frame    <= {2'b00, i_req_data & w_mask, i_req_len, i_req_is_dr};
        r_rsp_data <= '0;
      end else if (w_cap) begin
        r_rsp_data <= r_rsp_data | ({{(DATA_W-1){1'b0}}, i_tdo} << w_bidx);
      end
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_DONE) || (r_state == S_REJ);
  assign o_rsp_err   = (r_state == S_REJ);
  assign o_rsp_data  = r_rsp_data;
  assign o_tck       = r_tck;
  assign o_tms       = r_tms;
  assign o_tdi       = r_tdi;

endmodule
